edge_cache_responder: RTL and testbench
=======================================

Name: edge_cache_responder

Overview:
- Responder end of the ec_* edge-query interface driven by the Dijkstra core.
- Holds one adjacency-matrix row (all edges leaving ec_from_node) in a local row buffer, filled from external graph memory over an Avalon-MM pipelined read master.
- Serves ec_edge_value for ec_to_node with one-cycle latency on a row hit.
- Sits between the Dijkstra core and the on-chip/SDRAM graph store.

Parameters:
- MAX_NODES, `DEFAULT_MAX_NODES: row buffer depth.
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH: node index width.
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH: edge weight width (IEEE-754 single).
- ADDR_WIDTH, 32: byte address width of the memory master.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- number_of_nodes  in  INDEX_WIDTH  graph size N; row length; stable while ec_query=1.
- base_address  in  ADDR_WIDTH  byte address of matrix element [0][0].
- invalidate  in  1  one-cycle pulse; discards cached row (graph memory rewritten).
- ec_query  in  1  core requests edge service.
- ec_from_node  in  INDEX_WIDTH  row index.
- ec_to_node  in  INDEX_WIDTH  column index.
- ec_ready  out  1  ec_edge_value is valid for the current from/to.
- ec_edge_value  out  VALUE_WIDTH  weight of edge from→to.
- mem_read  out  1  Avalon read request.
- mem_address  out  ADDR_WIDTH  byte address.
- mem_waitrequest  in  1  slave stall.
- mem_readdata  in  VALUE_WIDTH  read response data.
- mem_readdatavalid  in  1  response strobe; responses return in order.

Behaviour:
- Reset values: state IDLE, row_valid=0, mem_read=0, mem_address=0, ec_edge_value=0, issue and receive counters 0. ec_ready=0 while in reset.
- Address rule: element[f][t] is at base_address + ((f*N + t) << 2). f*N is computed once at fetch start, then incremented by 4 per issued read. Arithmetic is unsigned and truncated to ADDR_WIDTH.
- States:
  - IDLE: when ec_query=1 and the row misses (row_valid=0 or cached_from≠ec_from_node), latch cached_from=ec_from_node, clear counters → FETCH. A hit → SERVE.
  - FETCH: mem_read=1 while issue_cnt<N. issue_cnt and mem_address advance only in cycles where mem_waitrequest=0. Each mem_readdatavalid writes mem_readdata to row[recv_cnt] and increments recv_cnt. When recv_cnt reaches N: row_valid=1 → SERVE.
  - SERVE: on ec_query=0 → IDLE. On ec_query=1 with a miss → refetch via the IDLE path in the next cycle.
- Read path: every cycle, rd_to_q<=ec_to_node and ec_edge_value<=row[ec_to_node]. If ec_to_node≥N, return `EC_NO_EDGE (+inf, 32'h7F800000) instead.
- ec_ready is combinational: state==SERVE && ec_query && row hit && rd_to_q==ec_to_node. A change of ec_to_node drops ready for exactly one cycle. A core that updates to_node and re-samples one cycle later therefore sees no stall.
- ec_from_node changes during FETCH: the fetch completes for the latched row, then misses in SERVE and refetches. A fetch is never abandoned mid-flight.
- ec_query falls during FETCH: the fetch completes, row_valid=1, then → IDLE.
- invalidate: clears row_valid immediately in any state. In FETCH it is deferred; the fetch completes but leaves row_valid=0.
- N=0: FETCH issues nothing and completes immediately; every lookup returns `EC_NO_EDGE.
- N>MAX_NODES: the fill is clamped to MAX_NODES entries and columns ≥MAX_NODES return `EC_NO_EDGE.
- Reset mid-FETCH: aborts at once, mem_read=0. Stray readdatavalid beats arriving in IDLE are ignored.

Decomposition:
- Shared package edge_cache_pkg holds:
  - typedef ec_state_t {IDLE, FETCH, SERVE};
  - `EC_NO_EDGE;
  - word-size shift constant 2.
- `EC_NO_EDGE also goes in constants.v so the core agrees on +inf.
- One sub-module, edge_row_buffer: simple dual-port RAM, MAX_NODES×VALUE_WIDTH, one write port, one synchronous read port.

Test Plan:
- Cold miss: N=4, base=0x1000, query from=2. Required: mem reads at 0x1020, 0x1024, 0x1028, 0x102C; then ec_ready=1 with to=1 → value equal to the word at 0x1024.
- Hit sweep: after the fill, step to 0..3 one per two cycles. Required: no further mem_read, and ready drops exactly one cycle after each to change.
- Waitrequest stall: hold mem_waitrequest high on the 2nd and 3rd read cycles. Required: mem_address holds 0x1024 throughout the stall, and exactly 4 reads are accepted.
- Row switch: change from 2→0 in SERVE. Required: ready=0, refetch at 0x1000..0x100C, then valid data from row 0.
- Out-of-range column: to=5 with N=4. Required: ec_edge_value=32'h7F800000 with ready=1.
- Reset/invalidate: assert reset_n=0 after 2 issued reads. Required: mem_read=0 at once, and late readdatavalid beats are ignored. Then pulse invalidate in SERVE; required: the next query refetches.

Source files
------------

// File: rtl/edge_cache_pkg.sv
// Shared types and constants for the edge-cache responder and the Dijkstra core it serves.
// EC_NO_EDGE is also exported as a macro so the core agrees on the +inf encoding.
`ifndef EC_NO_EDGE
`define EC_NO_EDGE 32'h7F80_0000
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 64
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 32
`endif

package edge_cache_pkg;

    localparam int unsigned DEFAULT_MAX_NODES   = `DEFAULT_MAX_NODES;
    localparam int unsigned DEFAULT_INDEX_WIDTH = `DEFAULT_INDEX_WIDTH;
    localparam int unsigned DEFAULT_VALUE_WIDTH = `DEFAULT_VALUE_WIDTH;

    // Matrix elements are 32-bit words; byte address = element index << WORD_SHIFT.
    localparam int unsigned WORD_SHIFT = 2;

    localparam logic [31:0] EC_NO_EDGE = `EC_NO_EDGE;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SERVE
    } ec_state_t;

endpackage

// File: rtl/edge_row_buffer.sv
// Simple dual-port row RAM: one write port, one registered read port.
module edge_row_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/edge_cache_responder.sv
// Edge-query responder: caches one adjacency-matrix row fetched over an Avalon-MM
// pipelined read master and serves edge weights with one-cycle latency on a row hit.
module edge_cache_responder
    import edge_cache_pkg::*;
#(
    parameter int unsigned MAX_NODES   = DEFAULT_MAX_NODES,
    parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int unsigned VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic [ADDR_WIDTH-1:0]  base_address,
    input  logic                   invalidate,
    input  logic                   ec_query,
    input  logic [INDEX_WIDTH-1:0] ec_from_node,
    input  logic [INDEX_WIDTH-1:0] ec_to_node,
    output logic                   ec_ready,
    output logic [VALUE_WIDTH-1:0] ec_edge_value,
    output logic                   mem_read,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    input  logic                   mem_waitrequest,
    input  logic [VALUE_WIDTH-1:0] mem_readdata,
    input  logic                   mem_readdatavalid
);

    localparam int unsigned CNT_W  = $clog2(MAX_NODES + 1);
    localparam int unsigned ROW_AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

    ec_state_t              state;
    logic                   row_valid;
    logic                   inval_pending;
    logic [INDEX_WIDTH-1:0] cached_from;
    logic [INDEX_WIDTH-1:0] rd_to_q;
    logic                   oor_q;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       recv_cnt;
    logic [CNT_W-1:0]       fill_n;
    logic                   hit;
    logic                   accept;
    logic                   row_we;
    logic [VALUE_WIDTH-1:0] row_rdata;

    // Rows longer than the buffer are clamped; the missing columns read as no-edge.
    assign fill_n = (32'(number_of_nodes) > MAX_NODES) ? CNT_W'(MAX_NODES)
                                                       : CNT_W'(number_of_nodes);
    assign hit    = row_valid && (cached_from == ec_from_node);
    assign accept = mem_read && !mem_waitrequest;
    assign row_we = (state == FETCH) && mem_readdatavalid && (recv_cnt < fill_n);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            row_valid     <= 1'b0;
            inval_pending <= 1'b0;
            cached_from   <= '0;
            issue_cnt     <= '0;
            recv_cnt      <= '0;
            mem_read      <= 1'b0;
            mem_address   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ec_query) begin
                        if (hit) begin
                            state <= SERVE;
                        end else begin
                            cached_from   <= ec_from_node;
                            issue_cnt     <= '0;
                            recv_cnt      <= '0;
                            row_valid     <= 1'b0;
                            inval_pending <= 1'b0;
                            mem_address   <= base_address +
                                ((ADDR_WIDTH'(ec_from_node) * ADDR_WIDTH'(number_of_nodes))
                                 << WORD_SHIFT);
                            mem_read      <= (fill_n != '0);
                            state         <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (accept) begin
                        issue_cnt   <= issue_cnt + 1'b1;
                        mem_address <= mem_address + (ADDR_WIDTH'(1) << WORD_SHIFT);
                    end
                    mem_read <= (issue_cnt + CNT_W'(accept)) < fill_n;
                    if (row_we) begin
                        recv_cnt <= recv_cnt + 1'b1;
                    end
                    // An invalidate seen mid-fill is remembered; the fill still completes.
                    if (invalidate) begin
                        inval_pending <= 1'b1;
                    end
                    if (recv_cnt == fill_n) begin
                        row_valid <= !(inval_pending || invalidate);
                        mem_read  <= 1'b0;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (!ec_query || !hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (invalidate && (state != FETCH)) begin
                row_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_to_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            rd_to_q <= ec_to_node;
            oor_q   <= 32'(ec_to_node) >= 32'(fill_n);
        end
    end

    edge_row_buffer #(
        .DEPTH  (MAX_NODES),
        .WIDTH  (VALUE_WIDTH),
        .ADDR_W (ROW_AW)
    ) u_row (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (row_we),
        .waddr   (ROW_AW'(recv_cnt)),
        .wdata   (mem_readdata),
        .raddr   (ROW_AW'(ec_to_node)),
        .rdata   (row_rdata)
    );

    assign ec_edge_value = oor_q ? VALUE_WIDTH'(EC_NO_EDGE) : row_rdata;

    // Ready waits one cycle after a column change so the registered read has caught up.
    assign ec_ready = (state == SERVE) && ec_query && hit && (rd_to_q == ec_to_node);

endmodule

// File: tb/tb_edge_cache_responder.sv
// Randomised self-checking bench: Avalon slave model plus a row-level reference model.
module tb_edge_cache_responder;

    localparam int unsigned MAXN = 8;
    localparam int unsigned IW   = 4;
    localparam int unsigned VW   = 32;
    localparam int unsigned AW   = 32;
    localparam logic [31:0] NO_EDGE = 32'h7F80_0000;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [IW-1:0] number_of_nodes;
    logic [AW-1:0] base_address;
    logic          invalidate;
    logic          ec_query;
    logic [IW-1:0] ec_from_node;
    logic [IW-1:0] ec_to_node;
    logic          ec_ready;
    logic [VW-1:0] ec_edge_value;
    logic          mem_read;
    logic [AW-1:0] mem_address;
    logic          mem_waitrequest   = 1'b0;
    logic [VW-1:0] mem_readdata      = '0;
    logic          mem_readdatavalid = 1'b0;

    edge_cache_responder #(
        .MAX_NODES   (MAXN),
        .INDEX_WIDTH (IW),
        .VALUE_WIDTH (VW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .number_of_nodes   (number_of_nodes),
        .base_address      (base_address),
        .invalidate        (invalidate),
        .ec_query          (ec_query),
        .ec_from_node      (ec_from_node),
        .ec_to_node        (ec_to_node),
        .ec_ready          (ec_ready),
        .ec_edge_value     (ec_edge_value),
        .mem_read          (mem_read),
        .mem_address       (mem_address),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: graph memory contents and the row/address rules.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic int unsigned fill_of(input int unsigned n);
        return (n > MAXN) ? MAXN : n;
    endfunction

    function automatic logic [31:0] elem_addr(input logic [31:0] base, input int unsigned n,
                                              input int unsigned f, input int unsigned t);
        logic [31:0] idx;
        idx = f * n + t;
        return base + (idx << 2);
    endfunction

    function automatic logic [31:0] exp_value(input logic [31:0] base, input int unsigned n,
                                              input int unsigned f, input int unsigned t);
        if (t >= fill_of(n)) return NO_EDGE;
        return mem_word(elem_addr(base, n, f, t));
    endfunction

    // Avalon slave model; only this block writes the logs and response queue.
    int unsigned cyc = 0;
    int unsigned rd_cycles = 0;
    int unsigned last_resp = 0;
    logic [31:0] acc_log[$];
    logic [31:0] stall_log[$];
    logic [31:0] resp_addr[$];
    int unsigned resp_time[$];
    bit          stall_mode = 1'b0;
    int unsigned stall_base = 0;
    bit          rand_wait  = 1'b0;
    int unsigned fixed_lat  = 0;

    always @(negedge clock) begin
        int unsigned t;
        cyc++;
        if (resp_addr.size() != 0 && resp_time[0] <= cyc) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = mem_word(resp_addr.pop_front());
            void'(resp_time.pop_front());
        end else begin
            mem_readdatavalid = 1'b0;
            mem_readdata      = $urandom;
        end
        if (mem_read) begin
            if (stall_mode)
                mem_waitrequest = (rd_cycles - stall_base == 1) || (rd_cycles - stall_base == 2);
            else
                mem_waitrequest = rand_wait && ($urandom_range(0, 2) == 0);
            rd_cycles++;
            if (mem_waitrequest) begin
                stall_log.push_back(mem_address);
            end else begin
                acc_log.push_back(mem_address);
                t = cyc + ((fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3));
                if (t <= last_resp) t = last_resp + 1;
                last_resp = t;
                resp_addr.push_back(mem_address);
                resp_time.push_back(t);
            end
        end else begin
            mem_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_ready(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            #1;
            seen = ec_ready;
        end
        check_value({tag, "_ready"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_accepts(input int unsigned target);
        for (int i = 0; i < 200 && acc_log.size() < target; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_bus_idle(input string tag);
        for (int i = 0; i < 200 && resp_addr.size() != 0; i++) @(negedge clock);
        check_value({tag, "_bus_idle"}, 32'(resp_addr.size()), 32'd0);
    endtask

    task automatic check_fetch(input string tag, input int unsigned mark,
                               input logic [31:0] base, input int unsigned n,
                               input int unsigned f, input int unsigned reps);
        int unsigned fill;
        fill = fill_of(n);
        check_value({tag, "_count"}, 32'(acc_log.size() - mark), 32'(fill * reps));
        for (int r = 0; r < int'(reps); r++)
            for (int t = 0; t < int'(fill); t++)
                if (mark + r * fill + t < acc_log.size())
                    check_value({tag, "_addr"}, acc_log[mark + r * fill + t],
                                elem_addr(base, n, f, t));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned mark, smark, rmark, n_cur, f, t, t2, mfrom;
        logic [31:0] base_cur;
        bit          mvalid, hit;

        reset_n         = 1'b0;
        number_of_nodes = 4'd4;
        base_address    = 32'h1000;
        invalidate      = 1'b0;
        ec_query        = 1'b0;
        ec_from_node    = '0;
        ec_to_node      = '0;
        repeat (3) @(negedge clock);
        #1;
        check_value("rst_ready", 32'(ec_ready), 32'd0);
        check_value("rst_mem_read", 32'(mem_read), 32'd0);
        check_value("rst_mem_address", mem_address, 32'd0);
        check_value("rst_edge_value", ec_edge_value, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Cold miss on row 2 with waitrequest on the 2nd and 3rd read cycles.
        mark = acc_log.size(); smark = stall_log.size(); stall_base = rd_cycles;
        stall_mode   = 1'b1;
        ec_from_node = 4'd2;
        ec_to_node   = 4'd1;
        ec_query     = 1'b1;
        wait_ready("cold");
        check_value("cold_value", ec_edge_value, exp_value(32'h1000, 4, 2, 1));
        check_fetch("cold", mark, 32'h1000, 4, 2, 1);
        check_value("stall_cycles", 32'(stall_log.size() - smark), 32'd2);
        for (int i = int'(smark); i < stall_log.size(); i++)
            check_value("stall_addr", stall_log[i], 32'h1024);
        stall_mode = 1'b0;

        // Hit sweep: each column change drops ready for one cycle, no new reads.
        rmark = rd_cycles;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            ec_to_node = IW'(c);
            #1;
            check_value("sweep_drop", 32'(ec_ready), 32'd0);
            @(negedge clock);
            #1;
            check_value("sweep_ready", 32'(ec_ready), 32'd1);
            check_value("sweep_value", ec_edge_value, exp_value(32'h1000, 4, 2, c));
        end
        check_value("sweep_no_reads", rd_cycles - rmark, 32'd0);

        // Column beyond N.
        @(negedge clock);
        ec_to_node = 4'd5;
        @(negedge clock);
        #1;
        check_value("oor_ready", 32'(ec_ready), 32'd1);
        check_value("oor_value", ec_edge_value, NO_EDGE);

        // Row switch 2 -> 0 while serving.
        @(negedge clock);
        mark = acc_log.size();
        ec_from_node = 4'd0;
        ec_to_node   = 4'd2;
        #1;
        check_value("switch_drop", 32'(ec_ready), 32'd0);
        wait_ready("switch");
        check_value("switch_value", ec_edge_value, exp_value(32'h1000, 4, 0, 2));
        check_fetch("switch", mark, 32'h1000, 4, 0, 1);

        // Invalidate while serving forces a refetch of the same row.
        @(negedge clock);
        mark = acc_log.size();
        invalidate = 1'b1;
        @(negedge clock);
        invalidate = 1'b0;
        #1;
        check_value("inval_drop", 32'(ec_ready), 32'd0);
        wait_ready("inval");
        check_value("inval_value", ec_edge_value, exp_value(32'h1000, 4, 0, 2));
        check_fetch("inval", mark, 32'h1000, 4, 0, 1);

        // Invalidate mid-fill: the fill completes, then the row is fetched again.
        @(negedge clock);
        mark = acc_log.size();
        rand_wait    = 1'b1;
        ec_from_node = 4'd3;
        ec_to_node   = 4'd3;
        wait_accepts(mark + 1);
        invalidate = 1'b1;
        @(negedge clock);
        invalidate = 1'b0;
        wait_ready("midinval");
        check_value("midinval_value", ec_edge_value, exp_value(32'h1000, 4, 3, 3));
        check_fetch("midinval", mark, 32'h1000, 4, 3, 2);

        // Reset after two issued reads; late beats must be ignored.
        @(negedge clock);
        ec_query = 1'b0;
        wait_bus_idle("pre_reset");
        @(negedge clock);
        rand_wait = 1'b0;
        fixed_lat = 6;
        mark = acc_log.size();
        ec_from_node = 4'd1;
        ec_to_node   = 4'd0;
        ec_query     = 1'b1;
        wait_accepts(mark + 2);
        reset_n = 1'b0;
        #1;
        check_value("reset_mem_read", 32'(mem_read), 32'd0);
        check_value("reset_ready", 32'(ec_ready), 32'd0);
        ec_query = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        rmark = rd_cycles;
        wait_bus_idle("stray");
        fixed_lat = 0;
        check_value("stray_no_reads", rd_cycles - rmark, 32'd0);
        @(negedge clock);
        mark = acc_log.size();
        ec_query = 1'b1;
        wait_ready("post_reset");
        check_value("post_reset_value", ec_edge_value, exp_value(32'h1000, 4, 1, 0));
        check_fetch("post_reset", mark, 32'h1000, 4, 1, 1);
        @(negedge clock);
        ec_query = 1'b0;

        // Randomised queries against the row-cache reference model.
        mvalid = 1'b1; mfrom = 1; n_cur = 4; base_cur = 32'h1000;
        for (int it = 0; it < 40; it++) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
                n_cur    = $urandom_range(0, 12);
                base_cur = $urandom & 32'hFFFF_FFFC;
                number_of_nodes = IW'(n_cur);
                base_address    = base_cur;
                invalidate      = 1'b1;
                @(negedge clock);
                invalidate = 1'b0;
                mvalid     = 1'b0;
            end
            f = $urandom_range(0, 15);
            t = $urandom_range(0, 15);
            rand_wait = 1'($urandom_range(0, 1));
            hit   = mvalid && (mfrom == f);
            mark  = acc_log.size();
            rmark = rd_cycles;
            ec_from_node = IW'(f);
            ec_to_node   = IW'(t);
            ec_query     = 1'b1;
            wait_ready("rand");
            check_value("rand_value", ec_edge_value, exp_value(base_cur, n_cur, f, t));
            if (hit) check_value("rand_hit_no_reads", rd_cycles - rmark, 32'd0);
            else     check_fetch("rand_fill", mark, base_cur, n_cur, f, 1);
            mvalid = 1'b1;
            mfrom  = f;
            t2 = (t + $urandom_range(1, 15)) % 16;
            @(negedge clock);
            ec_to_node = IW'(t2);
            #1;
            check_value("rand_drop", 32'(ec_ready), 32'd0);
            @(negedge clock);
            #1;
            check_value("rand_ready", 32'(ec_ready), 32'd1);
            check_value("rand_value2", ec_edge_value, exp_value(base_cur, n_cur, f, t2));
            @(negedge clock);
            ec_query = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
